// File: rtl/fade_pkg.sv
// Shared types and helpers for the RGB colour-wheel fade sequencer.
// Duty arithmetic runs at a fixed CALC_W so the package stays independent of PWM_INTERVAL.
package fade_pkg;

   localparam int PHASE_COUNT = 6;
   localparam int CALC_W      = 16;

   typedef enum logic [2:0] {
      PH_RG_UP = 3'd0,
      PH_R_DN  = 3'd1,
      PH_B_UP  = 3'd2,
      PH_G_DN  = 3'd3,
      PH_R_UP  = 3'd4,
      PH_B_DN  = 3'd5
   } phase_t;

   typedef struct packed {
      logic [CALC_W-1:0] r;
      logic [CALC_W-1:0] g;
      logic [CALC_W-1:0] b;
   } rgb_t;

   // One channel moves per phase; level never exceeds max-1, so max-level cannot underflow.
   function automatic rgb_t duty_for(input phase_t ph,
                                     input logic [CALC_W-1:0] level,
                                     input logic [CALC_W-1:0] max);
      rgb_t d;
      logic [CALC_W-1:0] fall;
      fall = max - level;
      d    = '0;
      case (ph)
         PH_RG_UP: begin d.r = max;   d.g = level; d.b = '0;    end
         PH_R_DN:  begin d.r = fall;  d.g = max;   d.b = '0;    end
         PH_B_UP:  begin d.r = '0;    d.g = max;   d.b = level; end
         PH_G_DN:  begin d.r = '0;    d.g = fall;  d.b = max;   end
         PH_R_UP:  begin d.r = level; d.g = '0;    d.b = max;   end
         PH_B_DN:  begin d.r = max;   d.g = '0;    d.b = fall;  end
         default:  begin d.r = max;   d.g = '0;    d.b = '0;    end
      endcase
      return d;
   endfunction

   function automatic phase_t next_phase(input phase_t ph);
      phase_t n;
      if (int'(ph) >= PHASE_COUNT - 1) n = PH_RG_UP;
      else                             n = phase_t'(ph + 3'd1);
      return n;
   endfunction

endpackage

// File: rtl/fade_step_timer.sv
// Enable-gated modulo-STEP_CYCLES timer that raises a pending-step flag at terminal count.
// The flag is consumed by the apply strobe, which also wins when both land on the same edge.
module fade_step_timer
   import fade_pkg::*;
#(
   parameter int STEP_CYCLES = 1667
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic apply,
   output logic terminal,
   output logic pending
);

   localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

   logic [TW-1:0] count;

   assign terminal = en && (count == LAST);

   // Frozen rather than cleared while en is low, so a resumed fade keeps its step phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         count <= '0;
      else if (terminal) count <= '0;
      else if (en)       count <= count + TW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         pending <= 1'b0;
      else if (apply)    pending <= 1'b0;
      else if (terminal) pending <= 1'b1;
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour-wheel fade controller: owns the PWM period counter and produces R/G/B duties.
// Duties change only on the edge where pwm_cnt wraps, so downstream comparators never glitch.
module rgb_fade_sequencer
   import fade_pkg::*;
#(
   parameter  int PWM_INTERVAL = 1200,
   parameter  int STEP_CYCLES  = 1667,
   localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic [DW-1:0] duty_r,
   output logic [DW-1:0] duty_g,
   output logic [DW-1:0] duty_b,
   output logic [DW-1:0] pwm_cnt,
   output logic          pwm_start,
   output logic [2:0]    phase,
   output logic          cycle_done
);

   localparam logic [DW-1:0] MAX        = DW'(PWM_INTERVAL);
   localparam logic [DW-1:0] LAST_CNT   = DW'(PWM_INTERVAL - 1);
   localparam logic [DW-1:0] LAST_LEVEL = DW'(PWM_INTERVAL - 1);

   generate
      if (STEP_CYCLES < PWM_INTERVAL) begin : g_bad_step
         $error("rgb_fade_sequencer: STEP_CYCLES must be >= PWM_INTERVAL");
      end
   endgenerate

   phase_t        phase_q;
   phase_t        phase_d;
   logic [DW-1:0] level_q;
   logic [DW-1:0] level_d;
   logic          done_d;
   logic          wrap;
   logic          terminal;
   logic          pending;
   logic          apply;
   rgb_t          duty_next;
   logic          unused_duty_hi;

   assign wrap  = (pwm_cnt == LAST_CNT);
   assign apply = wrap && (pending || terminal);

   fade_step_timer #(
      .STEP_CYCLES (STEP_CYCLES)
   ) u_step_timer (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .apply    (apply),
      .terminal (terminal),
      .pending  (pending)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     pwm_cnt <= '0;
      else if (wrap) pwm_cnt <= '0;
      else           pwm_cnt <= pwm_cnt + DW'(1);
   end

   // At most one step per period boundary; the last level of a phase rolls into the next phase.
   always_comb begin
      phase_d = phase_q;
      level_d = level_q;
      done_d  = 1'b0;
      if (apply) begin
         if (level_q == LAST_LEVEL) begin
            level_d = '0;
            phase_d = next_phase(phase_q);
            done_d  = (phase_q == PH_B_DN);
         end else begin
            level_d = level_q + DW'(1);
         end
      end
   end

   assign duty_next = duty_for(phase_d, CALC_W'(level_d), CALC_W'(MAX));
   assign unused_duty_hi = ^{duty_next.r[CALC_W-1:DW],
                             duty_next.g[CALC_W-1:DW],
                             duty_next.b[CALC_W-1:DW]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q    <= PH_RG_UP;
         level_q    <= '0;
         cycle_done <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         level_q    <= level_d;
         cycle_done <= done_d;
      end
   end

   // Registered from the next phase/level so new duties appear together with pwm_start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_r <= MAX;
         duty_g <= '0;
         duty_b <= '0;
      end else if (apply) begin
         duty_r <= duty_next.r[DW-1:0];
         duty_g <= duty_next.g[DW-1:0];
         duty_b <= duty_next.b[DW-1:0];
      end
   end

   assign pwm_start = (pwm_cnt == '0);
   assign phase     = phase_q;

endmodule
